// File: rtl/and_gate_exerciser.sv
// ---------------------------------------------------------------------------
// and_gate_exerciser
//
// Purpose:
//   Driver/responder for a 2-input AND gate. On start it walks the four
//   {a,b} input combinations LOOPS times. Each vector is held for
//   SETTLE_CYCLES cycles, and then the gate output is sampled for one cycle
//   and compared with a&b. It reports a saturating mismatch count, the first
//   failing vector and an overall pass flag. All outputs are registered.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   start            in   run request, honoured only in IDLE
//   drv_a, drv_b     out  drives gate inputs a and b
//   dut_out          in   gate output under test, used only in SAMPLE
//   busy             out  high in SETTLE and SAMPLE
//   done             out  one-cycle pulse at the end of a run
//   pass             out  last completed run had no mismatches
//   err_count        out  saturating mismatch count of current/last run
//   first_fail_valid out  a mismatch has been captured this run
//   first_fail_vec   out  {a,b} of the first mismatch
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, results of the last run held
// SETTLE | vector driven, settle counter running down to 0
// SAMPLE | compare dut_out with a&b, then advance to the next vector
// FINISH | one cycle: done pulse, pass resolved, drives back to 00
// ---------------------------------------------------------------------------
module and_gate_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST  = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          vec_q, vec_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic [1:0]          drv_q, drv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                ffv_q, ffv_d;
  logic [1:0]          ffvec_q, ffvec_d;

  logic                mismatch;
  logic [ERR_W-1:0]    err_next;

  // The compare uses the registered drives, i.e. exactly what the gate sees.
  assign mismatch = dut_out != (drv_q[1] & drv_q[0]);

  always_comb begin
    err_next = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_next = err_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    drv_d   = drv_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_RELOAD;
          vec_d   = 2'd0;
          loop_d  = '0;
          drv_d   = 2'd0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = 2'd0;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_SAMPLE: begin
        err_d = err_next;
        if (mismatch && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec_q;
        end
        if ((vec_q == 2'd3) && (loop_q == LOOP_LAST)) begin
          state_d = ST_FINISH;
          drv_d   = 2'd0;
          // err_next already includes this final sample.
          pass_d  = (err_next == '0);
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_RELOAD;
          // The 2-bit vector wraps 3 -> 0 in the same cycle the loop steps.
          vec_d   = vec_q + 2'd1;
          drv_d   = vec_q + 2'd1;
          if (vec_q == 2'd3) begin
            loop_d = loop_q + 1'b1;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags follow the next state so that they are registered.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= 2'd0;
      loop_q  <= '0;
      drv_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign drv_a            = drv_q[1];
  assign drv_b            = drv_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_and_gate_exerciser.sv
// ---------------------------------------------------------------------------
// tb_and_gate_exerciser
//
// Four exerciser instances share one clock and reset:
//   u0 defaults, with a gate model selectable by mode0
//   u1 LOOPS=2 with the gate output stuck at 0
//   u2 ERR_W=2, LOOPS=4 with the gate output stuck at 1
//   u3 SETTLE_CYCLES=1 with the gate output wrong only in the settle cycle
// ---------------------------------------------------------------------------
module tb_and_gate_exerciser;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0] start_v, busy_v, done_v, pass_v, ffv_v, da_v, db_v;
  logic [7:0] err0, err1, err3;
  logic [1:0] err2;
  logic [1:0] ffvec0, ffvec1, ffvec2, ffvec3;
  logic       dut_out0, dut_out1, dut_out2, dut_out3;
  int         mode0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // mode0: 0 good AND, 1 stuck-0, 2 stuck-1, 3 NAND, 4 out=a
  always_comb begin
    dut_out0 = da_v[0] & db_v[0];
    case (mode0)
      1: dut_out0 = 1'b0;
      2: dut_out0 = 1'b1;
      3: dut_out0 = ~(da_v[0] & db_v[0]);
      4: dut_out0 = da_v[0];
      default: dut_out0 = da_v[0] & db_v[0];
    endcase
  end

  assign dut_out1 = 1'b0;
  assign dut_out2 = 1'b1;

  and_gate_exerciser u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .drv_a(da_v[0]), .drv_b(db_v[0]),
    .dut_out(dut_out0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err0), .first_fail_valid(ffv_v[0]), .first_fail_vec(ffvec0)
  );

  and_gate_exerciser #(.LOOPS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .drv_a(da_v[1]), .drv_b(db_v[1]),
    .dut_out(dut_out1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err1), .first_fail_valid(ffv_v[1]), .first_fail_vec(ffvec1)
  );

  and_gate_exerciser #(.ERR_W(2), .LOOPS(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .drv_a(da_v[2]), .drv_b(db_v[2]),
    .dut_out(dut_out2), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err2), .first_fail_valid(ffv_v[2]), .first_fail_vec(ffvec2)
  );

  and_gate_exerciser #(.SETTLE_CYCLES(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .drv_a(da_v[3]), .drv_b(db_v[3]),
    .dut_out(dut_out3), .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
    .err_count(err3), .first_fail_valid(ffv_v[3]), .first_fail_vec(ffvec3)
  );

  typedef struct {
    logic a;
    logic b;
    logic busy;
    logic done;
  } cyc_t;

  typedef struct {
    int         mode;
    logic [7:0] err;
    logic       ffv;
    logic [1:0] vec;
    logic       pass;
  } res_t;

  cyc_t cyc[14];
  res_t res[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge where done is seen.
  task automatic wait_run(input int k, input int bound, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    for (int t = 0; t < bound; t++) begin
      if (done_v[k]) begin
        seen = 1'b1;
        break;
      end
      if (busy_v[k]) n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic start_run(input int k);
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  // One default-parameter run on u0, checked cycle by cycle against cyc[],
  // with start optionally re-asserted during cycles ra and rb.
  task automatic run_u0(input int r, input int ra, input int rb);
    mode0      = res[r].mode;
    start_v[0] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      start_v[0] = (i == ra) || (i == rb);
      chk("u0_drv",  {30'd0, da_v[0], db_v[0]}, {30'd0, cyc[i].a, cyc[i].b});
      chk("u0_busy", {31'd0, busy_v[0]}, {31'd0, cyc[i].busy});
      chk("u0_done", {31'd0, done_v[0]}, {31'd0, cyc[i].done});
      if (i == 0) begin
        chk("u0_clr_err",  {24'd0, err0}, 32'd0);
        chk("u0_clr_ffv",  {31'd0, ffv_v[0]}, 32'd0);
        chk("u0_clr_pass", {31'd0, pass_v[0]}, 32'd0);
      end
    end
    chk("u0_err",   {24'd0, err0}, {24'd0, res[r].err});
    chk("u0_ffv",   {31'd0, ffv_v[0]}, {31'd0, res[r].ffv});
    chk("u0_ffvec", {30'd0, ffvec0}, {30'd0, res[r].vec});
    chk("u0_pass",  {31'd0, pass_v[0]}, {31'd0, res[r].pass});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  seen;
    logic [1:0] v;

    // SETTLE=2: each vector = 2 settle + 1 sample cycles, then FINISH, then IDLE.
    cyc[0]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    cyc[1]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    cyc[2]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    cyc[3]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    cyc[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    cyc[5]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    cyc[6]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    cyc[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    cyc[8]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    cyc[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    cyc[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
    cyc[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
    cyc[12] = '{1'b0, 1'b0, 1'b0, 1'b1};
    cyc[13] = '{1'b0, 1'b0, 1'b0, 1'b0};

    res[0] = '{0, 8'd0, 1'b0, 2'b00, 1'b1};
    res[1] = '{1, 8'd1, 1'b1, 2'b11, 1'b0};
    res[2] = '{2, 8'd3, 1'b1, 2'b00, 1'b0};
    res[3] = '{3, 8'd4, 1'b1, 2'b00, 1'b0};
    res[4] = '{4, 8'd1, 1'b1, 2'b10, 1'b0};

    start_v  = '0;
    mode0    = 0;
    dut_out3 = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {28'd0, busy_v}, 32'd0);
    chk("rst_done", {28'd0, done_v}, 32'd0);
    chk("rst_pass", {28'd0, pass_v}, 32'd0);
    chk("rst_drv",  {24'd0, da_v, db_v}, 32'd0);
    chk("rst_err0", {24'd0, err0}, 32'd0);
    chk("rst_ffv",  {28'd0, ffv_v}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of gate models on default parameters.
    for (int r = 0; r < 5; r++) begin
      run_u0(r, -1, -1);
    end

    // Start re-asserted mid-run is ignored; then a fresh run clears results.
    run_u0(1, 3, 8);
    run_u0(0, -1, -1);

    // Asynchronous reset during SETTLE of vector 10.
    mode0      = 0;
    start_v[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
    end
    chk("arst_pre_drv",  {30'd0, da_v[0], db_v[0]}, 32'd2);
    chk("arst_pre_busy", {31'd0, busy_v[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_drv",   {30'd0, da_v[0], db_v[0]}, 32'd0);
    chk("arst_busy",  {31'd0, busy_v[0]}, 32'd0);
    chk("arst_done",  {31'd0, done_v[0]}, 32'd0);
    chk("arst_pass",  {31'd0, pass_v[0]}, 32'd0);
    chk("arst_err",   {24'd0, err0}, 32'd0);
    chk("arst_ffv",   {31'd0, ffv_v[0]}, 32'd0);
    chk("arst_ffvec", {30'd0, ffvec0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", {31'd0, done_v[0]}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle_done", {31'd0, done_v[0]}, 32'd0);
    run_u0(0, -1, -1);

    // LOOPS=2, stuck at 0: only 11 fails, twice.
    start_run(1);
    wait_run(1, 100, n, seen);
    chk("u1_done_seen", {31'd0, seen}, 32'd1);
    chk("u1_busy_len",  n, 32'd24);
    chk("u1_err",       {24'd0, err1}, 32'd2);
    chk("u1_ffv",       {31'd0, ffv_v[1]}, 32'd1);
    chk("u1_ffvec",     {30'd0, ffvec1}, 32'd3);
    chk("u1_pass",      {31'd0, pass_v[1]}, 32'd0);
    @(posedge clk); #1;
    chk("u1_done_pulse", {31'd0, done_v[1]}, 32'd0);

    // ERR_W=2, LOOPS=4, stuck at 1: 12 raw mismatches saturate at 3.
    start_run(2);
    wait_run(2, 200, n, seen);
    chk("u2_done_seen", {31'd0, seen}, 32'd1);
    chk("u2_busy_len",  n, 32'd48);
    chk("u2_err_sat",   {30'd0, err2}, 32'd3);
    chk("u2_ffv",       {31'd0, ffv_v[2]}, 32'd1);
    chk("u2_ffvec",     {30'd0, ffvec2}, 32'd0);
    chk("u2_pass",      {31'd0, pass_v[2]}, 32'd0);

    // SETTLE_CYCLES=1: vector i/2, even cycles settle (gate output wrong),
    // odd cycles sample (gate output correct).
    start_v[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start_v[3] = 1'b0;
      v = 2'(i / 2);
      if (i < 8) begin
        dut_out3 = (i % 2 == 0) ? ~(v[1] & v[0]) : (v[1] & v[0]);
        chk("u3_drv", {30'd0, da_v[3], db_v[3]}, {30'd0, v});
      end else begin
        dut_out3 = 1'b1;
      end
      chk("u3_busy", {31'd0, busy_v[3]}, {31'd0, (i < 8)});
      chk("u3_done", {31'd0, done_v[3]}, {31'd0, (i == 8)});
    end
    chk("u3_err",  {24'd0, err3}, 32'd0);
    chk("u3_ffv",  {31'd0, ffv_v[3]}, 32'd0);
    chk("u3_pass", {31'd0, pass_v[3]}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/and_gate_exerciser.md
Name: and_gate_exerciser

Overview:
- Self-checking driver/responder for the team's 2-input AND gate block. It sits on the opposite side of the gate's a/b/out interface.
- On each start request it drives all four input combinations onto the gate for a programmable number of passes. After each vector has settled it samples the gate output and compares it to the expected a&b.
- It reports the error count, the first failing vector, and pass/fail status.
- Used as an on-chip/bench harness around the gate and its future variants.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range ≥1.
- LOOPS, 1, number of full passes over the 4 vectors; legal range ≥1.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request, sampled on clk; honoured only in IDLE.
- drv_a  output  1  drives gate input a.
- drv_b  output  1  drives gate input b.
- dut_out  input  1  gate output under test.
- busy  output  1  high while a run is in progress (SETTLE or SAMPLE).
- done  output  1  single-cycle pulse at end of run.
- pass  output  1  1 when the last completed run had zero mismatches; held until the next accepted start.
- err_count  output  ERR_W  mismatches in current/last run; saturating.
- first_fail_valid  output  1  a mismatch has been captured in current/last run.
- first_fail_vec  output  2  {a,b} of first mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE; drv_a=drv_b=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0. Applies immediately, including mid-run; no done pulse is issued for an aborted run.
- All outputs are registered.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - On start=1, go to SETTLE next cycle.
  - On that transition: vec=0 ({drv_a,drv_b}=00), loop=0, settle counter=SETTLE_CYCLES-1, err_count=0, first_fail_valid=0, first_fail_vec=0, pass=0.
- SETTLE:
  - busy=1; drives {drv_a,drv_b}=vec.
  - Counter decrements each cycle.
  - Transition to SAMPLE on the cycle the counter reads 0, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle, busy=1, drives unchanged):
  - expected = drv_a & drv_b.
  - If dut_out != expected, err_count increments, saturating at 2^ERR_W-1.
  - If first_fail_valid=0 on a mismatch, capture first_fail_vec=vec and set first_fail_valid=1.
  - Then:
    - if vec==3 and loop==LOOPS-1, go to FINISH;
    - else vec=vec+1 (3 wraps to 0 and loop increments), reload the counter, go to SETTLE.
- FINISH (1 cycle):
  - busy=0, done=1.
  - pass = (final err_count==0), including the last sample's result.
  - Drives return to 00.
  - Next state IDLE.
- Latency: start accepted at edge k gives busy=1 from k+1 for 4·LOOPS·(SETTLE_CYCLES+1) cycles; done=1 in the following cycle.
- start is ignored in SETTLE, SAMPLE and FINISH; no queuing.
- start held high continuously restarts a run from IDLE one cycle after FINISH.
- dut_out is sampled only in SAMPLE and ignored at all other times. Metastability is out of scope; dut_out is synchronous to clk.
- Counters (settle, vec, loop) are wide enough for parameter maxima; vec wrap and loop increment occur in the same cycle.

Test Plan:
- Correct AND gate connected, defaults, pulse start → busy high 12 cycles; vectors 00,01,10,11 each held 3 cycles; done pulse at cycle 13; pass=1, err_count=0, first_fail_valid=0.
- dut_out stuck at 0, LOOPS=2 → only vector 11 fails: err_count=2, first_fail_vec=11, first_fail_valid=1, pass=0; done after 24 busy cycles.
- dut_out stuck at 1, ERR_W=2, LOOPS=4 → 12 raw mismatches, so err_count saturates at 3; first_fail_vec=00; pass=0.
- start re-asserted on cycles 3 and 8 of a run → ignored; run length and results identical to a single start; after done, a new start clears err_count/first_fail_valid and reruns.
- rst_n pulled low mid-SETTLE of vector 10 → all outputs 0 immediately (async); no done pulse; after release a new start runs a full clean pass with pass=1.
- SETTLE_CYCLES=1 → each vector occupies exactly 2 cycles; busy 8 cycles; dut_out toggled wrong only during the SETTLE cycle → no error counted (sampling only in SAMPLE).
